// File: rtl/fcmp_pkg.sv
// Shared encodings and defaults for the round-robin floating-point compare scheduler.
package fcmp_pkg;

    localparam logic [2:0] RM_LE = 3'b000;
    localparam logic [2:0] RM_LT = 3'b001;
    localparam logic [2:0] RM_EQ = 3'b010;

    localparam int TAG_W_DEF = 5;

endpackage

// File: rtl/fcmp_core.sv
// Combinational IEEE-754 single compare on raw bit patterns (no NaN or signed-zero special cases).
module fcmp_core
    import fcmp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rm,
    output logic [31:0] result
);

    logic equal;
    logic less_than;
    logic mag_lt;
    logic mag_gt;

    // Exponent sits above mantissa, so one unsigned compare of bits 30:0 orders both fields.
    assign equal  = (a == b);
    assign mag_lt = (a[30:0] < b[30:0]);
    assign mag_gt = (a[30:0] > b[30:0]);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        less_than = 1'b0;
        if (a[31] != b[31]) begin
            less_than = a[31];
        end else if (a[31]) begin
            less_than = mag_gt;
        end else begin
            less_than = mag_lt;
        end
    end

    always_comb begin
        result = '0;
        case (rm)
            RM_LE:   result[0] = equal | less_than;
            RM_LT:   result[0] = less_than;
            default: result[0] = equal;
        endcase
    end

endmodule

// File: rtl/fcmp_sched.sv
// Round-robin arbiter feeding a two-stage compare pipeline (S1 operands, S2 result) with full backpressure.
module fcmp_sched
    import fcmp_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_a,
    input  logic [NUM_REQ*32-1:0]      req_b,
    input  logic [NUM_REQ*3-1:0]       req_rm,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_data,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [$clog2(NUM_REQ)-1:0] rsp_src
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_a_q,     s1_a_d;
    logic [31:0]      s1_b_q,     s1_b_d;
    logic [2:0]       s1_rm_q,    s1_rm_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic [SRC_W-1:0] s1_src_q,   s1_src_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_res_q,   s2_res_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
    logic [SRC_W-1:0] s2_src_q,   s2_src_d;

    logic             grant_found;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] scan_idx;
    logic             s2_load_ok;
    logic             s1_adv;
    logic             s1_load_ok;
    logic             hs;
    logic [31:0]      core_result;

    fcmp_core u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .rm     (s1_rm_q),
        .result (core_result)
    );

    assign s2_load_ok = !s2_valid_q || rsp_ready;
    assign s1_adv     = s1_valid_q && s2_load_ok;
    assign s1_load_ok = !s1_valid_q || s2_load_ok;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Ready is masked during reset so no requester sees an accept while the pipeline is held clear.
    assign hs = grant_found && s1_load_ok && !rst;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_rm_d    = s1_rm_q;
        s1_tag_d   = s1_tag_q;
        s1_src_d   = s1_src_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_tag_d   = s2_tag_q;
        s2_src_d   = s2_src_q;

        if (hs) begin
            rr_ptr_d   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            s1_valid_d = 1'b1;
            s1_a_d     = req_a[int'(grant_idx)*32 +: 32];
            s1_b_d     = req_b[int'(grant_idx)*32 +: 32];
            s1_rm_d    = req_rm[int'(grant_idx)*3 +: 3];
            s1_tag_d   = req_tag[int'(grant_idx)*TAG_W +: TAG_W];
            s1_src_d   = grant_idx;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load_ok) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            s2_res_d = core_result;
            s2_tag_d = s1_tag_q;
            s2_src_d = s1_src_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: payload registers are reset as well, because the response outputs must read zero while in reset.
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_rm_q    <= '0;
            s1_tag_q   <= '0;
            s1_src_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_tag_q   <= '0;
            s2_src_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_rm_q    <= s1_rm_d;
            s1_tag_q   <= s1_tag_d;
            s1_src_q   <= s1_src_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_tag_q   <= s2_tag_d;
            s2_src_q   <= s2_src_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_data  = s2_res_q;
    assign rsp_tag   = s2_tag_q;
    assign rsp_src   = s2_src_q;

endmodule

// File: tb/tb_fcmp_sched.sv
// Scoreboard bench for fcmp_sched: expectations pushed at each handshake, compared as responses are consumed.
module tb_fcmp_sched;
    import fcmp_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 5;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*32-1:0]    req_a;
    logic [NUM_REQ*32-1:0]    req_b;
    logic [NUM_REQ*3-1:0]     req_rm;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [31:0]              rsp_data;
    logic [TAG_W-1:0]         rsp_tag;
    logic                     rsp_src;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             src;
    } rsp_t;

    rsp_t               sb_q[$];
    logic [NUM_REQ-1:0] hs_mask;
    int                 n_vec = 0;
    int                 n_err = 0;

    fcmp_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_rm    (req_rm),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_src   (rsp_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic model_cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        logic eq;
        logic lt;
        eq = (a == b);
        if (a == b)              lt = 1'b0;
        else if (a[31] != b[31]) lt = a[31];
        else if (!a[31])         lt = (a < b);
        else                     lt = (a > b);
        case (rm)
            3'b000:  return eq | lt;
            3'b001:  return lt;
            default: return eq;
        endcase
    endfunction

    function automatic logic [31:0] pick_fp();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h3F80_0000;
            3:       return 32'hBF80_0000;
            4:       return 32'h7FC0_0000;
            default: return $urandom;
        endcase
    endfunction

    // One clock: sample handshakes and responses on the falling edge, return 1 time unit after the rising edge.
    task automatic cycle();
        rsp_t exp;
        @(negedge clk);
        hs_mask = req_valid & req_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_mask[i]) begin
                exp.data = {31'b0, model_cmp(req_a[i*32 +: 32], req_b[i*32 +: 32], req_rm[i*3 +: 3])};
                exp.tag  = req_tag[i*TAG_W +: TAG_W];
                exp.src  = 1'(i);
                sb_q.push_back(exp);
            end
        end
        if (rsp_valid && rsp_ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rsp: got data=%h tag=%0d src=%0d, required no response", rsp_data, rsp_tag, rsp_src);
            end else begin
                exp = sb_q.pop_front();
                if (rsp_data !== exp.data || rsp_tag !== exp.tag || rsp_src !== exp.src) begin
                    n_err++;
                    $display("FAIL sb_rsp: got data=%h tag=%0d src=%0d, required data=%h tag=%0d src=%0d",
                             rsp_data, rsp_tag, rsp_src, exp.data, exp.tag, exp.src);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] rm, input logic [TAG_W-1:0] tag);
        req_valid[i]             = v;
        req_a[i*32 +: 32]        = a;
        req_b[i*32 +: 32]        = b;
        req_rm[i*3 +: 3]         = rm;
        req_tag[i*TAG_W +: TAG_W] = tag;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm, input logic [TAG_W-1:0] tag);
        int budget = 20;
        set_req(i, 1'b1, a, b, rm, tag);
        cycle();
        while (!hs_mask[i] && budget > 0) begin
            cycle();
            budget--;
        end
        n_vec++;
        if (!hs_mask[i]) begin
            n_err++;
            $display("FAIL issue_timeout: requester %0d got no ready, required handshake", i);
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int budget = 50;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (sb_q.size() > 0 && budget > 0) begin
            cycle();
            budget--;
        end
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
        end
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_idle: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_rm    = '0;
        req_tag   = '0;
        set_req(0, 1'b1, 32'h3F80_0000, 32'h3F80_0000, RM_EQ, 5'd7);
        set_req(1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, RM_EQ, 5'd9);
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (req_ready !== 2'b00)  begin n_err++; $display("FAIL rst_req_ready: got %b, required 00", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0)   begin n_err++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
        n_vec++; if (rsp_data !== 32'h0)   begin n_err++; $display("FAIL rst_rsp_data: got %h, required 0", rsp_data); end
        n_vec++; if (rsp_tag !== 5'd0)     begin n_err++; $display("FAIL rst_rsp_tag: got %0d, required 0", rsp_tag); end
        n_vec++; if (rsp_src !== 1'b0)     begin n_err++; $display("FAIL rst_rsp_src: got %0d, required 0", rsp_src); end
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_latency();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'h3F80_0000, 32'h4000_0000, RM_LT, 5'd3);
        #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL first_ready: got %b, required 01", req_ready); end
        cycle();
        req_valid = '0;
        n_vec++; if (hs_mask !== 2'b01)   begin n_err++; $display("FAIL lat_hs: got %b, required 01", hs_mask); end
        n_vec++; if (rsp_valid !== 1'b0)  begin n_err++; $display("FAIL lat_early: rsp_valid=%b one edge after handshake, required 0", rsp_valid); end
        cycle();
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h1 || rsp_tag !== 5'd3 || rsp_src !== 1'b0) begin
            n_err++;
            $display("FAIL lat_rsp: got valid=%b data=%h tag=%0d src=%0d, required valid=1 data=1 tag=3 src=0",
                     rsp_valid, rsp_data, rsp_tag, rsp_src);
        end
        drain();
    endtask

    task automatic test_ops();
        logic [31:0] va [8] = '{32'hBF80_0000, 32'h4000_0000, 32'h8000_0000, 32'h0000_0000,
                                32'hC000_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0001};
        logic [31:0] vb [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000,
                                32'hBF80_0000, 32'h7FC0_0000, 32'h3F80_0001, 32'h3F80_0000};
        logic [2:0]  vr [8] = '{3'b000, 3'b010, 3'b010, 3'b001, 3'b001, 3'b010, 3'b011, 3'b000};
        logic        ve [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            issue(1, va[k], vb[k], vr[k], 5'(k + 1));
            cycle();
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_data !== {31'b0, ve[k]}) begin
                n_err++;
                $display("FAIL op_%0d: got valid=%b data=%h, required valid=1 data=%h", k, rsp_valid, rsp_data, {31'b0, ve[k]});
            end
        end
        drain();
    endtask

    task automatic test_round_robin();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, pick_fp(), pick_fp(), 3'($urandom_range(0, 7)), 5'd10);
        set_req(1, 1'b1, pick_fp(), pick_fp(), 3'($urandom_range(0, 7)), 5'd11);
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_vec++;
            if (hs_mask !== 2'(1 << (k % 2))) begin
                n_err++;
                $display("FAIL rr_grant_%0d: got %b, required %b", k, hs_mask, 2'(1 << (k % 2)));
            end
            set_req(k % 2, 1'b1, pick_fp(), pick_fp(), 3'($urandom_range(0, 7)), 5'(10 + k % 2));
        end
        drain();
    endtask

    task automatic test_throughput();
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            set_req(0, 1'b1, pick_fp(), pick_fp(), 3'($urandom_range(0, 7)), 5'(k));
            cycle();
            n_vec++;
            if (hs_mask[0] !== 1'b1) begin n_err++; $display("FAIL tput_hs_%0d: got %b, required 1", k, hs_mask[0]); end
            if (k >= 1) begin
                n_vec++;
                if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL tput_valid_%0d: got %b, required 1", k, rsp_valid); end
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] a_tab [3] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000};
        logic [31:0] b_tab [3] = '{32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};
        logic [2:0]  r_tab [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] snap_data;
        logic [4:0]  snap_tag;
        logic        snap_src;
        int          k = 0;
        int          budget = 20;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_req(0, 1'b1, a_tab[k], b_tab[k], r_tab[k], 5'(20 + k));
            cycle();
            if (hs_mask[0]) k++;
        end
        n_vec++; if (k > 2)            begin n_err++; $display("FAIL bp_accepted: got %0d, required at most 2", k); end
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b, required 1", rsp_valid); end
        n_vec++; if (rsp_tag !== 5'd20)  begin n_err++; $display("FAIL bp_first_tag: got %0d, required 20", rsp_tag); end
        snap_data = rsp_data;
        snap_tag  = rsp_tag;
        snap_src  = rsp_src;
        set_req(1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, RM_EQ, 5'd30);
        for (int c = 0; c < 2; c++) begin
            cycle();
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_data !== snap_data || rsp_tag !== snap_tag || rsp_src !== snap_src) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got valid=%b data=%h tag=%0d src=%0d, required valid=1 data=%h tag=%0d src=%0d",
                         c, rsp_valid, rsp_data, rsp_tag, rsp_src, snap_data, snap_tag, snap_src);
            end
            n_vec++;
            if (hs_mask !== 2'b00) begin n_err++; $display("FAIL bp_stall_hs_%0d: got %b, required 00", c, hs_mask); end
        end
        req_valid[1] = 1'b0;
        rsp_ready    = 1'b1;
        while (k < 3 && budget > 0) begin
            set_req(0, 1'b1, a_tab[k], b_tab[k], r_tab[k], 5'(20 + k));
            cycle();
            if (hs_mask[0]) k++;
            budget--;
        end
        n_vec++; if (k != 3) begin n_err++; $display("FAIL bp_resume: accepted %0d, required 3", k); end
        drain();
    endtask

    task automatic test_reset_midflight();
        int k = 0;
        int budget = 20;
        rsp_ready = 1'b0;
        while (k < 2 && budget > 0) begin
            set_req(0, 1'b1, pick_fp(), pick_fp(), RM_LE, 5'(12 + k));
            cycle();
            if (hs_mask[0]) k++;
            budget--;
        end
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL mr_full: got rsp_valid=%b, required 1", rsp_valid); end
        rsp_ready    = 1'b1;
        req_valid[0] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mr_rsp_valid: got %b, required 0", rsp_valid); end
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL mr_req_ready: got %b, required 00", req_ready); end
        sb_q.delete();
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_vec++;
            if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mr_stale_%0d: got rsp_valid=%b, required 0", c, rsp_valid); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), pick_fp(), pick_fp(), 3'($urandom_range(0, 7)), 5'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_vec++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 0) begin
                n_err++;
                $display("FAIL rand_ready_%0d: got ready=%b valid=%b, required at most one bit within valid", c, req_ready, req_valid);
            end
            cycle();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_round_robin();
        test_throughput();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
